// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a single memory port between the instruction fetch
// unit (IFU) and the load/store unit (LSU). One transaction is outstanding at a
// time. All request and response paths use valid/ready handshakes.
// Optional feature macro: ARB_RR_EN. When it is defined, the arbiter uses
// round-robin arbitration. When it is not defined, the LSU has fixed priority
// over the IFU.
module mem_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ifu_req_valid,
   output logic                ifu_req_ready,
   input  logic [ADDR_W-1:0]   ifu_addr,
   output logic                ifu_rsp_valid,
   input  logic                ifu_rsp_ready,
   output logic [DATA_W-1:0]   ifu_rsp_data,
   input  logic                lsu_req_valid,
   output logic                lsu_req_ready,
   input  logic [ADDR_W-1:0]   lsu_addr,
   input  logic                lsu_wen,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wmask,
   output logic                lsu_rsp_valid,
   input  logic                lsu_rsp_ready,
   output logic [DATA_W-1:0]   lsu_rsp_data,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_wen,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic                mem_rsp_valid,
   output logic                mem_rsp_ready,
   input  logic [DATA_W-1:0]   mem_rsp_data
);
   localparam int MASK_W = DATA_W / 8;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                wen_q, wen_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [MASK_W-1:0]   wmask_q, wmask_d;
   logic                owner_q, owner_d;   // 0 = IFU, 1 = LSU
   logic [DATA_W-1:0]   data_q, data_d;
   logic                grant_lsu;
   logic                idle_open;
   logic                ifu_hs, lsu_hs, rsp_hs;
`ifdef ARB_RR_EN
   logic                last_grant_q, last_grant_d;  // 1 = LSU granted last
`endif

   // Arbitration: choose which valid requester may see req_ready this cycle
   always_comb begin
      grant_lsu = lsu_req_valid;
`ifdef ARB_RR_EN
      if (ifu_req_valid && lsu_req_valid)
         grant_lsu = !last_grant_q;
`endif
   end

   // Requests are accepted only in IDLE. Accepts are also blocked while reset
   // is asserted, so the ready outputs are 0 during reset.
   assign idle_open     = rst && (state_q == S_IDLE);
   assign ifu_req_ready = idle_open && ifu_req_valid && !grant_lsu;
   assign lsu_req_ready = idle_open && lsu_req_valid && grant_lsu;
   assign ifu_hs        = ifu_req_valid && ifu_req_ready;
   assign lsu_hs        = lsu_req_valid && lsu_req_ready;
   assign rsp_hs        = owner_q ? lsu_rsp_ready : ifu_rsp_ready;

   assign mem_req_valid = (state_q == S_ISSUE);
   assign mem_rsp_ready = (state_q == S_WAIT);
   assign ifu_rsp_valid = (state_q == S_RESP) && !owner_q;
   assign lsu_rsp_valid = (state_q == S_RESP) && owner_q;
   assign ifu_rsp_data  = data_q;
   assign lsu_rsp_data  = data_q;
   assign mem_addr      = addr_q;
   assign mem_wen       = wen_q;
   assign mem_wdata     = wdata_q;
   assign mem_wmask     = wmask_q;

   // Next-state logic: capture the request, issue it, wait for the response,
   // then hold the response for the owner
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wen_d   = wen_q;
      wdata_d = wdata_q;
      wmask_d = wmask_q;
      owner_d = owner_q;
      data_d  = data_q;
`ifdef ARB_RR_EN
      last_grant_d = last_grant_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (lsu_hs) begin
               addr_d  = lsu_addr;
               wen_d   = lsu_wen;
               wdata_d = lsu_wdata;
               wmask_d = lsu_wmask;
               owner_d = 1'b1;
               state_d = S_ISSUE;
            end else if (ifu_hs) begin
               // A fetch is always a plain read.
               addr_d  = ifu_addr;
               wen_d   = 1'b0;
               wdata_d = '0;
               wmask_d = '0;
               owner_d = 1'b0;
               state_d = S_ISSUE;
            end
`ifdef ARB_RR_EN
            if (lsu_hs || ifu_hs)
               last_grant_d = lsu_hs;
`endif
         end
         S_ISSUE: begin
            if (mem_req_ready)
               state_d = S_WAIT;
         end
         S_WAIT: begin
            if (mem_rsp_valid) begin
               // A write acknowledgement returns zero data.
               data_d  = wen_q ? '0 : mem_rsp_data;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_hs)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and latched-request registers. Reset drops any in-flight transaction.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         wen_q   <= 1'b0;
         wdata_q <= '0;
         wmask_q <= '0;
         owner_q <= 1'b0;
         data_q  <= '0;
`ifdef ARB_RR_EN
         last_grant_q <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wen_q   <= wen_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
         owner_q <= owner_d;
         data_q  <= data_d;
`ifdef ARB_RR_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. It runs directed tests. A scoreboard checks
// the downstream requests and the requester responses in order.
module tb_mem_port_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready;
   logic [31:0] ifu_addr, ifu_rsp_data;
   logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_ready;
   logic [31:0] lsu_addr, lsu_wdata, lsu_rsp_data;
   logic [3:0]  lsu_wmask;
   logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, mem_rsp_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rsp_data, mem_rsp_drv;
   logic [3:0]  mem_wmask;
   logic        auto_data;

   int checks = 0;
   int failures = 0;

   typedef struct {logic port; logic [31:0] data;} rsp_t;
   typedef struct {logic [31:0] addr; logic wen; logic [31:0] wdata; logic [3:0] wmask;} mreq_t;
   rsp_t  rsp_q[$];
   mreq_t mreq_q[$];

   // The memory model returns the address XOR 0x5A5A0000, or a fixed value if one is forced.
   assign mem_rsp_data = auto_data ? (mem_addr ^ 32'h5A5A_0000) : mem_rsp_drv;

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_data(ifu_rsp_data),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
      .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
      .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_data(lsu_rsp_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_data(mem_rsp_data)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_mreq(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] m);
      mreq_t e;
      e.addr = a; e.wen = w; e.wdata = d; e.wmask = m;
      mreq_q.push_back(e);
   endtask

   task automatic push_rsp(input logic p, input logic [31:0] d);
      rsp_t e;
      e.port = p; e.data = d;
      rsp_q.push_back(e);
   endtask

   // Monitor: compares each handshake on the memory side and the requester side with the queued expectation.
   initial begin
      mreq_t m;
      rsp_t  r;
      forever begin
         @(negedge clk);
         if (rst) begin
            if (mem_req_valid && mem_req_ready) begin
               if (mreq_q.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL mem_req_unexpected actual=addr 0x%0h required=none", mem_addr);
               end else begin
                  m = mreq_q.pop_front();
                  $display("TXN mem_req addr=0x%08h wen=%0d wdata=0x%08h wmask=0x%0h", mem_addr, mem_wen, mem_wdata, mem_wmask);
                  chk("mem_req_fields", {mem_addr, mem_wen, mem_wmask}, {m.addr, m.wen, m.wmask});
                  chk("mem_req_wdata", mem_wdata, m.wdata);
               end
            end
            if (ifu_rsp_valid && lsu_rsp_valid) begin
               checks++; failures++;
               $display("FAIL rsp_both_valid actual=both required=one");
            end
            if ((ifu_rsp_valid && ifu_rsp_ready) || (lsu_rsp_valid && lsu_rsp_ready)) begin
               if (rsp_q.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL rsp_unexpected actual=port %0d required=none", lsu_rsp_valid);
               end else begin
                  r = rsp_q.pop_front();
                  $display("TXN rsp port=%s data=0x%08h", lsu_rsp_valid ? "lsu" : "ifu",
                           lsu_rsp_valid ? lsu_rsp_data : ifu_rsp_data);
                  chk("rsp_port", {63'd0, lsu_rsp_valid}, {63'd0, r.port});
                  chk("rsp_data", lsu_rsp_valid ? lsu_rsp_data : ifu_rsp_data, r.data);
               end
            end
         end
      end
   end

   initial begin
      int ifu_grants, lsu_grants;
      rst = 1'b0;
      ifu_req_valid = 1'b1; ifu_addr = '0; ifu_rsp_ready = 1'b0;
      lsu_req_valid = 1'b1; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
      lsu_rsp_ready = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      mem_rsp_drv = '0; auto_data = 1'b1;
      tick(); tick();
      // Reset state: the ready outputs stay 0 even while both requesters are valid.
      chk("rst_ifu_req_ready", ifu_req_ready, 0);
      chk("rst_lsu_req_ready", lsu_req_ready, 0);
      chk("rst_mem_outs", {mem_req_valid, mem_rsp_ready, mem_wen, ifu_rsp_valid, lsu_rsp_valid}, 0);
      chk("rst_mem_addr", mem_addr, 0);
      ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();

      // Test 1: IFU read with a zero-wait memory. Check the timing of each cycle.
      auto_data = 1'b0; mem_rsp_drv = 32'h0000_0413;
      mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; ifu_rsp_ready = 1'b1;
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
      push_mreq(32'h8000_0000, 1'b0, 32'h0, 4'h0);
      push_rsp(1'b0, 32'h0000_0413);
      #1;
      chk("t1_ready_N", {ifu_req_ready, lsu_req_ready}, 2'b10);
      tick(); ifu_req_valid = 1'b0;
      chk("t1_memvalid_N1", {mem_req_valid, ifu_req_ready}, 2'b10);
      tick();
      chk("t1_wait_N2", {mem_rsp_ready, ifu_rsp_valid}, 2'b10);
      tick();
      chk("t1_rsp_N3", {ifu_rsp_valid, lsu_rsp_valid, ifu_rsp_data}, {2'b10, 32'h0000_0413});
      tick();
      chk("t1_idle_N4", {ifu_rsp_valid, lsu_rsp_valid, mem_req_valid}, 3'b000);
      mem_rsp_valid = 1'b0; mem_req_ready = 1'b0; auto_data = 1'b1;

      // Test 2: LSU write. mem_req_ready is held low for 3 cycles, and the write is acknowledged with data 0.
      lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0100; lsu_wen = 1'b1;
      lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF; lsu_rsp_ready = 1'b1;
      push_mreq(32'h8000_0100, 1'b1, 32'hDEAD_BEEF, 4'hF);
      push_rsp(1'b1, 32'h0);
      #1;
      chk("t2_lsu_ready", {ifu_req_ready, lsu_req_ready}, 2'b01);
      tick();
      lsu_req_valid = 1'b0; lsu_addr = 32'h1234_5678; lsu_wdata = 32'h0; lsu_wmask = 4'h0; lsu_wen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("t2_issue_stable", {mem_req_valid, mem_wen, mem_wmask, mem_addr, mem_wdata},
             {1'b1, 1'b1, 4'hF, 32'h8000_0100, 32'hDEAD_BEEF});
         tick();
      end
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b1;
      tick();
      mem_rsp_valid = 1'b0;
      chk("t2_write_ack", {lsu_rsp_valid, ifu_rsp_valid, lsu_rsp_data}, {2'b10, 32'h0});
      tick();

      // Test 3: both requesters valid for 3 back-to-back transactions
      mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; ifu_rsp_ready = 1'b1; lsu_rsp_ready = 1'b1;
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0010;
      lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0200; lsu_wen = 1'b0;
      lsu_wdata = 32'h1111_1111; lsu_wmask = 4'h0;
`ifdef ARB_RR_EN
      push_mreq(32'h8000_0010, 1'b0, 32'h0, 4'h0);        push_rsp(1'b0, 32'hDA5A_0010);
      push_mreq(32'h8000_0200, 1'b0, 32'h1111_1111, 4'h0); push_rsp(1'b1, 32'hDA5A_0200);
      push_mreq(32'h8000_0010, 1'b0, 32'h0, 4'h0);        push_rsp(1'b0, 32'hDA5A_0010);
`else
      for (int i = 0; i < 3; i++) begin
         push_mreq(32'h8000_0200, 1'b0, 32'h1111_1111, 4'h0); push_rsp(1'b1, 32'hDA5A_0200);
      end
`endif
      #1;
      ifu_grants = 0; lsu_grants = 0;
      for (int i = 0; i < 12; i++) begin
         if (ifu_req_ready) ifu_grants++;
         if (lsu_req_ready) lsu_grants++;
         if (i == 11) begin ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; end
         tick();
      end
`ifdef ARB_RR_EN
      chk("t3_grant_counts", {ifu_grants[15:0], lsu_grants[15:0]}, {16'd2, 16'd1});
`else
      chk("t3_grant_counts", {ifu_grants[15:0], lsu_grants[15:0]}, {16'd0, 16'd3});
`endif

      // Test 4: the IFU holds rsp_ready low for 5 cycles in RESP
      ifu_rsp_ready = 1'b0; ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0020;
      push_mreq(32'h8000_0020, 1'b0, 32'h0, 4'h0);
      push_rsp(1'b0, 32'hDA5A_0020);
      tick(); ifu_req_valid = 1'b0;
      tick(); tick();
      lsu_req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("t4_hold", {ifu_rsp_valid, ifu_rsp_data, ifu_req_ready, lsu_req_ready, mem_req_valid},
             {1'b1, 32'hDA5A_0020, 3'b000});
         tick();
      end
      lsu_req_valid = 1'b0; ifu_rsp_ready = 1'b1;
      tick();
      chk("t4_released", {ifu_rsp_valid, mem_req_valid}, 2'b00);

      // Test 5: reset is asserted in WAIT, and a late memory response arrives after the release
      mem_rsp_valid = 1'b0;
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0030;
      push_mreq(32'h8000_0030, 1'b0, 32'h0, 4'h0);
      #1;
      chk("t5_accept", ifu_req_ready, 1);
      tick(); ifu_req_valid = 1'b0;
      tick();
      chk("t5_in_wait", mem_rsp_ready, 1);
      ifu_req_valid = 1'b1;
      rst = 1'b0;
      #1;
      chk("t5_rst_outs", {ifu_req_ready, lsu_req_ready, mem_req_valid, mem_rsp_ready,
                          ifu_rsp_valid, lsu_rsp_valid, mem_wen}, 7'b0);
      chk("t5_rst_regs", {mem_addr, ifu_rsp_data}, 64'h0);
      tick();
      ifu_req_valid = 1'b0; rst = 1'b1; mem_rsp_valid = 1'b1;
      #1;
      chk("t5_late_rsp_ignored", mem_rsp_ready, 0);
      tick();
      chk("t5_no_rsp", {ifu_rsp_valid, lsu_rsp_valid, mem_req_valid}, 3'b000);
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040;
      push_mreq(32'h8000_0040, 1'b0, 32'h0, 4'h0);
      push_rsp(1'b0, 32'hDA5A_0040);
      #1;
      chk("t5_post_accept", ifu_req_ready, 1);
      tick(); ifu_req_valid = 1'b0;
      for (int i = 0; i < 20 && rsp_q.size() != 0; i++) tick();
      chk("t5_drain_rsp", rsp_q.size(), 0);
      mem_rsp_valid = 1'b0;

      // After a fresh reset, a simultaneous request is granted according to the mode
      rst = 1'b0; tick(); rst = 1'b1;
      ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
      #1;
`ifdef ARB_RR_EN
      chk("post_rst_grant", {ifu_req_ready, lsu_req_ready}, 2'b10);
`else
      chk("post_rst_grant", {ifu_req_ready, lsu_req_ready}, 2'b01);
`endif
      ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
      tick(); tick();
      chk("mreq_queue_empty", mreq_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
